// File: rtl/mem_access_stage_if.sv
// Avalon-MM master bus between the memory stage and the data memory / interconnect.
// The stage is the master: it drives the command side and receives the read response.
interface mem_access_stage_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;

    modport master (
        output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        input  avm_readdata, avm_waitrequest, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        output avm_readdata, avm_waitrequest, avm_readdatavalid
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage of the pipeline: converts EX/MEM load/store requests into a single
// Avalon-MM transaction, stalls upstream while it is in flight, aligns load data,
// and flags misaligned or illegal accesses before anything reaches the bus.
module mem_access_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ALUResult,
    input  logic [31:0] StoreData,
    input  logic [2:0]  funct3,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [4:0]  instr5b,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    output logic [31:0] oData,
    output logic [31:0] oAddress,
    output logic [4:0]  oinstr5b,
    output logic        oMemtoReg,
    output logic        oRegWrite,
    output logic        oMisaligned,
    output logic        stall,
    mem_access_stage_if.master avm
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_rdata;

    logic        w_any_op;
    logic        w_both_op;
    logic        w_active;
    logic        w_illegal_f3;
    logic        w_misalign;
    logic        w_exception;
    logic        w_start;
    logic [3:0]  w_byteenable;
    logic [31:0] w_writedata;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

    assign w_any_op  = MemRead | MemWrite;
    assign w_both_op = MemRead & MemWrite;
    assign w_active  = MemRead ^ MemWrite;

    // Reserved sizes for any op; unsigned sizes make no sense for stores.
    assign w_illegal_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                          (MemWrite && funct3[2]);

    // Halfword needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
    assign w_misalign = ((funct3[1:0] == 2'b01) && ALUResult[0]) ||
                        ((funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));

    // Exceptions are only reported while the op is first presented; nothing is issued.
    assign w_exception = (r_state == IDLE) && w_any_op &&
                         (w_both_op || w_illegal_f3 || w_misalign);
    assign w_start     = (r_state == IDLE) && w_active && !w_illegal_f3 && !w_misalign;

    // Byte lanes and lane-replicated store data for the selected size.
    always_comb begin
        w_byteenable = 4'b1111;
        w_writedata  = StoreData;
        case (funct3[1:0])
            2'b00: begin
                w_byteenable = 4'b0001 << ALUResult[1:0];
                w_writedata  = {4{StoreData[7:0]}};
            end
            2'b01: begin
                w_byteenable = 4'b0011 << {ALUResult[1], 1'b0};
                w_writedata  = {2{StoreData[15:0]}};
            end
            default: begin
                w_byteenable = 4'b1111;
                w_writedata  = StoreData;
            end
        endcase
    end

    // Bring the addressed byte/half down to bit 0, then sign- or zero-extend.
    assign w_shifted = avm.avm_readdata >> {ALUResult[1:0], 3'b000};

    // Load extraction from the read response.
    always_comb begin
        w_load_data = avm.avm_readdata;
        case (funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
            3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
            default: w_load_data = avm.avm_readdata;
        endcase
    end

    // Transaction FSM with registered bus command outputs and captured read data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state            <= IDLE;
            r_rdata            <= 32'd0;
            avm.avm_address    <= 32'd0;
            avm.avm_read       <= 1'b0;
            avm.avm_write      <= 1'b0;
            avm.avm_byteenable <= 4'd0;
            avm.avm_writedata  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        avm.avm_address    <= {ALUResult[31:2], 2'b00};
                        avm.avm_byteenable <= w_byteenable;
                        avm.avm_writedata  <= w_writedata;
                        avm.avm_read       <= MemRead;
                        avm.avm_write      <= MemWrite;
                        r_state            <= CMD;
                    end
                end
                CMD: begin
                    // Command is held unchanged until the slave accepts it.
                    if (!avm.avm_waitrequest) begin
                        avm.avm_read  <= 1'b0;
                        avm.avm_write <= 1'b0;
                        r_state       <= avm.avm_write ? DONE : RESP;
                    end
                end
                RESP: begin
                    if (avm.avm_readdatavalid) begin
                        r_rdata <= w_load_data;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign stall       = w_start || (r_state == CMD) || (r_state == RESP);
    assign oMisaligned = w_exception;
    assign oRegWrite   = RegWrite && !stall && !w_exception;
    // Inputs are stable through the transaction, so MemRead still marks a load in DONE.
    assign oData       = ((r_state == DONE) && MemRead) ? r_rdata : 32'd0;
    assign oAddress    = ALUResult;
    assign oinstr5b    = instr5b;
    assign oMemtoReg   = MemtoReg;

endmodule
